fwd_hazard_ctrl: RTL and testbench
==================================

FWD_HAZARD_CTRL -- requirements
Module: fwd_hazard_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock, all state updates on the rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port id_rs1, input, 5 bits: source register 1 of the instruction in ID.
REQ-004 SHALL have port id_rs2, input, 5 bits: source register 2 of the instruction in ID.
REQ-005 SHALL have port id_rd, input, 5 bits: destination register of the instruction in ID.
REQ-006 SHALL have port id_regwrite, input, 1 bit: the ID instruction writes id_rd.
REQ-007 SHALL have port id_memread, input, 1 bit: the ID instruction is a load.
REQ-008 SHALL have port id_valid, input, 1 bit: ID holds a real instruction.
REQ-009 SHALL have port flush, input, 1 bit: kill the ID instruction (taken branch or jump).
REQ-010 SHALL have port fwd_a, output, 2 bits: operand-A select for the EX-stage 3:1 operand mux.
REQ-011 SHALL have port fwd_b, output, 2 bits: operand-B select for the EX-stage 3:1 operand mux.
REQ-012 SHALL have port stall, output, 1 bit: hold PC and IF/ID this cycle.
REQ-013 SHALL have port ex_bubble, output, 1 bit: the EX stage holds a bubble.

Function
REQ-014 SHALL use the select encoding 00 = register-file data, 01 = WB-stage result, 10 = MEM-stage ALU result; 11 SHALL never be driven.
REQ-015 SHALL hold internal stage records {rd, regwrite, memread, valid} for EX, MEM and WB.
REQ-016 SHALL advance the records every cycle: ID->EX, EX->MEM, MEM->WB; the old WB record is discarded.
REQ-017 SHALL load the EX record with a bubble (valid=0, regwrite=0, memread=0) when stall=1, flush=1 or id_valid=0.
REQ-018 SHALL drive stall combinationally high when all of the following hold: EX.valid, EX.memread, EX.rd != 0, id_valid, flush=0, and id_rs1 or id_rs2 equals EX.rd.
REQ-019 SHALL NOT stall for a non-load in EX; forwarding covers that case.
REQ-020 SHALL register fwd_a and fwd_b on each edge where the ID instruction enters EX, computed per source register rsN as follows:
- 10 if EX.regwrite, EX.valid, EX.rd != 0 and EX.rd == rsN;
- else 01 if MEM.regwrite, MEM.valid, MEM.rd != 0 and MEM.rd == rsN;
- else 00.
REQ-021 SHALL give the nearer (younger) producer priority when both EX and MEM match.
REQ-022 SHALL register fwd_a/fwd_b as 00 when a bubble enters EX (stall, flush or !id_valid).
REQ-023 SHALL never forward register x0, regardless of regwrite.
REQ-024 SHALL make flush override stall: with flush=1, stall=0 and a bubble enters EX.
REQ-025 SHALL drive ex_bubble = !EX.valid as a registered value.
REQ-026 SHALL leave a producer that is in WB while the consumer is in ID to the register file (write-before-read); this block does not cover that case.
REQ-027 SHALL after a 1-cycle load-use stall register a select of 01 for the dependent operand (the load is then in MEM).

Reset
REQ-028 SHALL, while rst=1 at a rising edge, clear all stage records to bubbles and set fwd_a=00, fwd_b=00, ex_bubble=1.
REQ-029 SHALL hold stall=0 from the first cycle after reset, because EX is then a bubble.
REQ-030 SHALL abort any stall in progress when rst is asserted mid-stall; no forwarding state survives reset.

Verification
REQ-031 Back-to-back ALU dependency: add x5 in ID, next cycle sub rs1=x5 in ID -> after the edge, fwd_a=10, fwd_b=00, stall=0.
REQ-032 Distance-2 dependency: add x5, nop, or rs2=x5 -> fwd_b=01 when the or enters EX.
REQ-033 Load-use: lw x7, then add rs1=x7 -> stall=1 for exactly one cycle, ex_bubble=1 the next cycle, then fwd_a=01 when the add enters EX.
REQ-034 Double match: add x3, add x3, sub rs1=x3, rs2=x3 -> fwd_a=10, fwd_b=10 (EX priority).
REQ-035 x0 and flush: addi x0 followed by use of x0 -> selects 00; lw x7 followed by dependent add with flush=1 -> stall=0 and a bubble enters EX.
REQ-036 Reset mid-stall: assert rst while stall=1 -> next cycle fwd_a=fwd_b=00, ex_bubble=1, stall=0.

Source files
------------

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding-select and load-use hazard control for a 5-stage in-order pipeline.
// Tracks {rd, regwrite, memread, valid} for EX/MEM/WB and registers the EX operand-mux selects.
module fwd_hazard_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic [4:0] id_rd,
  input  logic       id_regwrite,
  input  logic       id_memread,
  input  logic       id_valid,
  input  logic       flush,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b,
  output logic       stall,
  output logic       ex_bubble
);

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_WB  = 2'b01;
  localparam logic [1:0] SEL_MEM = 2'b10;

  logic [4:0] r_ex_rd,  r_mem_rd,  r_wb_rd;
  logic       r_ex_rw,  r_mem_rw,  r_wb_rw;
  logic       r_ex_mr,  r_mem_mr,  r_wb_mr;
  logic       r_ex_v,   r_mem_v,   r_wb_v;
  logic [1:0] r_fwd_a,  r_fwd_b;
  logic       r_ex_bubble;

  logic [4:0] w_id_rs   [2];
  logic [1:0] w_sel_next[2];
  logic [1:0] w_rs_hit_ex;
  logic       w_ex_prod;
  logic       w_mem_prod;
  logic       w_stall;
  logic       w_bubble_in;

  assign w_id_rs[0] = id_rs1;
  assign w_id_rs[1] = id_rs2;

  // A producer only counts if it is real, writes a register, and that register is not x0.
  assign w_ex_prod  = r_ex_v  && r_ex_rw  && (r_ex_rd  != 5'd0);
  assign w_mem_prod = r_mem_v && r_mem_rw && (r_mem_rd != 5'd0);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      assign w_rs_hit_ex[gi] = (w_id_rs[gi] == r_ex_rd);

      // EX producer is younger than MEM producer, so it wins when both match.
      always_comb begin
        w_sel_next[gi] = SEL_RF;
        if (w_ex_prod && (r_ex_rd == w_id_rs[gi])) begin
          w_sel_next[gi] = SEL_MEM;
        end else if (w_mem_prod && (r_mem_rd == w_id_rs[gi])) begin
          w_sel_next[gi] = SEL_WB;
        end
      end
    end
  endgenerate

  // Load in EX whose result the ID instruction needs: data is not ready until after MEM.
  assign w_stall = r_ex_v && r_ex_mr && (r_ex_rd != 5'd0) && id_valid && !flush
                   && (|w_rs_hit_ex);

  assign w_bubble_in = w_stall || flush || !id_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ex_rd     <= 5'd0;
      r_ex_rw     <= 1'b0;
      r_ex_mr     <= 1'b0;
      r_ex_v      <= 1'b0;
      r_mem_rd    <= 5'd0;
      r_mem_rw    <= 1'b0;
      r_mem_mr    <= 1'b0;
      r_mem_v     <= 1'b0;
      r_wb_rd     <= 5'd0;
      r_wb_rw     <= 1'b0;
      r_wb_mr     <= 1'b0;
      r_wb_v      <= 1'b0;
      r_fwd_a     <= SEL_RF;
      r_fwd_b     <= SEL_RF;
      r_ex_bubble <= 1'b1;
    end else begin
      r_wb_rd  <= r_mem_rd;
      r_wb_rw  <= r_mem_rw;
      r_wb_mr  <= r_mem_mr;
      r_wb_v   <= r_mem_v;
      r_mem_rd <= r_ex_rd;
      r_mem_rw <= r_ex_rw;
      r_mem_mr <= r_ex_mr;
      r_mem_v  <= r_ex_v;
      if (w_bubble_in) begin
        r_ex_rd <= 5'd0;
        r_ex_rw <= 1'b0;
        r_ex_mr <= 1'b0;
        r_ex_v  <= 1'b0;
        r_fwd_a <= SEL_RF;
        r_fwd_b <= SEL_RF;
      end else begin
        r_ex_rd <= id_rd;
        r_ex_rw <= id_regwrite;
        r_ex_mr <= id_memread;
        r_ex_v  <= 1'b1;
        r_fwd_a <= w_sel_next[0];
        r_fwd_b <= w_sel_next[1];
      end
      r_ex_bubble <= w_bubble_in;
    end
  end

  // The WB record and MEM.memread are kept for completeness but feed no decision here.
  logic w_unused;
  assign w_unused = ^{r_wb_rd, r_wb_rw, r_wb_mr, r_wb_v, r_mem_mr};

  assign fwd_a     = r_fwd_a;
  assign fwd_b     = r_fwd_b;
  assign stall     = w_stall;
  assign ex_bubble = r_ex_bubble;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed-vector bench for fwd_hazard_ctrl; expected values are hand-derived per scenario.
module tb_fwd_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       id_regwrite, id_memread, id_valid, flush;
  logic [1:0] fwd_a, fwd_b;
  logic       stall, ex_bubble;

  int checks = 0;
  int errors = 0;

  fwd_hazard_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_rd       (id_rd),
    .id_regwrite (id_regwrite),
    .id_memread  (id_memread),
    .id_valid    (id_valid),
    .flush       (flush),
    .fwd_a       (fwd_a),
    .fwd_b       (fwd_b),
    .stall       (stall),
    .ex_bubble   (ex_bubble)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s got=%0h", tag, got);
    end
  endtask

  task automatic set_id(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input logic rw, input logic mr, input logic v, input logic fl);
    id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_regwrite = rw; id_memread = mr; id_valid = v; flush = fl;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic nop2();
    set_id(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    set_id(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    chk("rst_fwd_a", 32'(fwd_a), 32'd0);
    chk("rst_fwd_b", 32'(fwd_b), 32'd0);
    chk("rst_bubble", 32'(ex_bubble), 32'd1);
    chk("rst_stall", 32'(stall), 32'd0);
    rst = 1'b0;

    // back-to-back ALU dependency: add x5 ; sub rs1=x5
    set_id(5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    chk("b2b_add_in_ex", 32'(ex_bubble), 32'd0);
    set_id(5'd5, 5'd6, 5'd8, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("b2b_no_stall", 32'(stall), 32'd0);
    tick();
    chk("b2b_fwd_a", 32'(fwd_a), 32'd2);
    chk("b2b_fwd_b", 32'(fwd_b), 32'd0);
    nop2();

    // distance-2: add x5 ; nop ; or rs2=x5
    set_id(5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    set_id(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("d2_nop_bubble", 32'(ex_bubble), 32'd1);
    chk("d2_nop_fwd_a", 32'(fwd_a), 32'd0);
    set_id(5'd9, 5'd5, 5'd10, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    chk("d2_fwd_a", 32'(fwd_a), 32'd0);
    chk("d2_fwd_b", 32'(fwd_b), 32'd1);
    nop2();

    // load-use: lw x7 ; add rs1=x7
    set_id(5'd2, 5'd0, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    set_id(5'd7, 5'd0, 5'd11, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("lu_stall", 32'(stall), 32'd1);
    tick();
    chk("lu_bubble", 32'(ex_bubble), 32'd1);
    chk("lu_bubble_fwd_a", 32'(fwd_a), 32'd0);
    chk("lu_stall_gone", 32'(stall), 32'd0);
    tick();
    chk("lu_fwd_a", 32'(fwd_a), 32'd1);
    chk("lu_fwd_b", 32'(fwd_b), 32'd0);
    chk("lu_add_in_ex", 32'(ex_bubble), 32'd0);
    nop2();

    // load-use through rs2, and a load to x0 never stalls
    set_id(5'd2, 5'd0, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    set_id(5'd1, 5'd7, 5'd11, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("lu_rs2_stall", 32'(stall), 32'd1);
    nop2();
    set_id(5'd2, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    set_id(5'd0, 5'd0, 5'd11, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("lw_x0_no_stall", 32'(stall), 32'd0);
    nop2();

    // double match: add x3 ; add x3 ; sub x3,x3 -> EX wins
    set_id(5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    set_id(5'd4, 5'd4, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    set_id(5'd3, 5'd3, 5'd12, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    chk("dbl_fwd_a", 32'(fwd_a), 32'd2);
    chk("dbl_fwd_b", 32'(fwd_b), 32'd2);
    nop2();

    // producer without regwrite (store-like) in MEM must not forward
    set_id(5'd1, 5'd2, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    set_id(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    set_id(5'd5, 5'd5, 5'd10, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    chk("norw_fwd_a", 32'(fwd_a), 32'd0);
    chk("norw_fwd_b", 32'(fwd_b), 32'd0);
    nop2();

    // x0 is never forwarded
    set_id(5'd1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    set_id(5'd0, 5'd0, 5'd13, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("x0_no_stall", 32'(stall), 32'd0);
    tick();
    chk("x0_fwd_a", 32'(fwd_a), 32'd0);
    chk("x0_fwd_b", 32'(fwd_b), 32'd0);
    nop2();

    // flush overrides load-use stall
    set_id(5'd2, 5'd0, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    set_id(5'd7, 5'd0, 5'd11, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("flush_no_stall", 32'(stall), 32'd0);
    tick();
    chk("flush_bubble", 32'(ex_bubble), 32'd1);
    chk("flush_fwd_a", 32'(fwd_a), 32'd0);
    nop2();

    // reset asserted mid-stall
    set_id(5'd2, 5'd0, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    set_id(5'd7, 5'd7, 5'd11, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("rs_stall_before", 32'(stall), 32'd1);
    rst = 1'b1;
    tick();
    chk("rs_fwd_a", 32'(fwd_a), 32'd0);
    chk("rs_fwd_b", 32'(fwd_b), 32'd0);
    chk("rs_bubble", 32'(ex_bubble), 32'd1);
    chk("rs_stall", 32'(stall), 32'd0);
    rst = 1'b0;
    tick();
    chk("rs_after_fwd_a", 32'(fwd_a), 32'd0);
    chk("rs_after_bubble", 32'(ex_bubble), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
